// File: rtl/sr_latch_pkg.sv
// rtl/sr_latch_pkg.sv - shared constants, decode enum and helper for sr_latch
package sr_latch_pkg;

  // Reset values: stored state clears, synchronizers idle high (inputs are active-low)
  localparam logic Q_RST     = 1'b0;
  localparam logic SYNC_IDLE = 1'b1;

  // Decoded condition of the synchronized active-low S/R pair
  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    SET    = 2'd1,
    RESET  = 2'd2,
    FORBID = 2'd3
  } cond_e;

  // Map the active-low (s, r) pair onto a decoded condition
  function automatic cond_e decode_cond(input logic s, input logic r);
    cond_e c;
    case ({s, r})
      2'b11:   c = HOLD;
      2'b01:   c = SET;
      2'b10:   c = RESET;
      default: c = FORBID;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// rtl/bit_synchronizer.sv - parameterized single-bit flop-chain synchronizer
module bit_synchronizer #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Zero depth: input is sampled directly by the consumer
      assign q = d;
    end else begin : g_chain
      logic [DEPTH-1:0] chain;

      // Shift the input through DEPTH flops; reset loads the idle level
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          chain <= {DEPTH{RST_VAL}};
        end else begin
          chain[0] <= d;
          for (int i = 1; i < DEPTH; i++) begin
            chain[i] <= chain[i-1];
          end
        end
      end

      assign q = chain[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/sr_latch.sv
// rtl/sr_latch.sv - clocked model of an active-low NAND-style SR latch
module sr_latch
  import sr_latch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int RACE_KEEP   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic S,
  input  logic R,
  output logic Q,
  output logic Qn,
  output logic invalid,
  output logic race
);

  logic  s_sy;
  logic  r_sy;
  cond_e cond;

  logic  stored;
  logic  stored_nxt;
  logic  q_nxt;
  logic  qn_nxt;
  logic  invalid_nxt;
  logic  race_nxt;

  bit_synchronizer #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_s (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (S),
    .q     (s_sy)
  );

  bit_synchronizer #(
    .DEPTH   (SYNC_STAGES),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_r (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (R),
    .q     (r_sy)
  );

  assign cond = decode_cond(s_sy, r_sy);

  // Next stored state and outputs; the registered invalid flag doubles as
  // "previous synchronized cycle was forbidden" for race detection
  always_comb begin
    stored_nxt  = stored;
    q_nxt       = stored;
    qn_nxt      = ~stored;
    invalid_nxt = 1'b0;
    race_nxt    = 1'b0;
    case (cond)
      SET: begin
        stored_nxt = 1'b1;
        q_nxt      = 1'b1;
        qn_nxt     = 1'b0;
      end
      RESET: begin
        stored_nxt = 1'b0;
        q_nxt      = 1'b0;
        qn_nxt     = 1'b1;
      end
      FORBID: begin
        q_nxt       = 1'b1;
        qn_nxt      = 1'b1;
        invalid_nxt = 1'b1;
      end
      default: begin
        if (invalid) begin
          race_nxt = 1'b1;
          if (RACE_KEEP == 0) begin
            stored_nxt = Q_RST;
          end
        end
        q_nxt  = stored_nxt;
        qn_nxt = ~stored_nxt;
      end
    endcase
  end

  // Stored state and outputs all update on the same edge; reset wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stored  <= Q_RST;
      Q       <= Q_RST;
      Qn      <= ~Q_RST;
      invalid <= 1'b0;
      race    <= 1'b0;
    end else begin
      stored  <= stored_nxt;
      Q       <= q_nxt;
      Qn      <= qn_nxt;
      invalid <= invalid_nxt;
      race    <= race_nxt;
    end
  end

endmodule

// File: tb/tb_sr_latch.sv
// tb/tb_sr_latch.sv - self-checking bench for sr_latch (keep and clear race policies)
module tb_sr_latch;

  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic S;
  logic R;
  logic q_k, qn_k, inv_k, race_k;
  logic q_c, qn_c, inv_c, race_c;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic pipe_s[$];
  logic pipe_r[$];
  logic m_store_k, m_store_c, m_prev_forbid;
  logic e_q_k, e_qn_k, e_q_c, e_qn_c, e_inv, e_race;

  always #5 clk = ~clk;

  sr_latch #(.SYNC_STAGES(SYNC), .RACE_KEEP(1)) dut_keep (
    .clk(clk), .rst_n(rst_n), .S(S), .R(R),
    .Q(q_k), .Qn(qn_k), .invalid(inv_k), .race(race_k)
  );

  sr_latch #(.SYNC_STAGES(SYNC), .RACE_KEEP(0)) dut_clr (
    .clk(clk), .rst_n(rst_n), .S(S), .R(R),
    .Q(q_c), .Qn(qn_c), .invalid(inv_c), .race(race_c)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: inputs seen SYNC edges late, then the latch truth table
  task automatic model(input logic s, input logic r, input logic rst);
    logic ss, rr, rc;
    if (!rst) begin
      pipe_s.delete();
      pipe_r.delete();
      for (int i = 0; i < SYNC; i++) begin
        pipe_s.push_back(1'b1);
        pipe_r.push_back(1'b1);
      end
      m_store_k = 1'b0; m_store_c = 1'b0; m_prev_forbid = 1'b0;
      e_q_k = 1'b0; e_qn_k = 1'b1; e_q_c = 1'b0; e_qn_c = 1'b1;
      e_inv = 1'b0; e_race = 1'b0;
      return;
    end
    pipe_s.push_back(s);
    pipe_r.push_back(r);
    ss = pipe_s.pop_front();
    rr = pipe_r.pop_front();
    rc = m_prev_forbid && ss && rr;
    e_race = rc;
    e_inv = 1'b0;
    if (!ss && !rr) begin
      e_inv = 1'b1;
    end else if (!ss) begin
      m_store_k = 1'b1; m_store_c = 1'b1;
    end else if (!rr) begin
      m_store_k = 1'b0; m_store_c = 1'b0;
    end else if (rc) begin
      m_store_c = 1'b0;
    end
    if (e_inv) begin
      e_q_k = 1'b1; e_qn_k = 1'b1; e_q_c = 1'b1; e_qn_c = 1'b1;
    end else begin
      e_q_k = m_store_k; e_qn_k = !m_store_k;
      e_q_c = m_store_c; e_qn_c = !m_store_c;
    end
    m_prev_forbid = !ss && !rr;
  endtask

  task automatic step(input logic s, input logic r, input logic rst);
    S = s; R = r; rst_n = rst;
    @(posedge clk);
    model(s, r, rst);
    #1;
    chk("q_keep", q_k, e_q_k);
    chk("qn_keep", qn_k, e_qn_k);
    chk("invalid_keep", inv_k, e_inv);
    chk("race_keep", race_k, e_race);
    chk("q_clr", q_c, e_q_c);
    chk("qn_clr", qn_c, e_qn_c);
    chk("invalid_clr", inv_c, e_inv);
    chk("race_clr", race_c, e_race);
  endtask

  task automatic run(input logic s, input logic r, input logic rst, input int n);
    for (int i = 0; i < n; i++) step(s, r, rst);
  endtask

  initial begin
    S = 1'b1; R = 1'b1; rst_n = 1'b0;
    // Reset and idle
    run(1, 1, 0, 2);
    chk("reset_q", q_k, 1'b0);
    chk("reset_qn", qn_k, 1'b1);
    run(1, 1, 1, 3);
    // Set: Q rises on the third edge after S falls
    step(0, 1, 1);
    step(0, 1, 1);
    chk("set_latency_q_before", q_k, 1'b0);
    step(0, 1, 1);
    chk("set_latency_q_at3", q_k, 1'b1);
    run(0, 1, 1, 7);
    run(1, 1, 1, 5);
    chk("set_hold_q", q_k, 1'b1);
    // Reset
    run(1, 0, 1, 10);
    run(1, 1, 1, 5);
    chk("reset_hold_q", q_k, 1'b0);
    // Forbidden from Q=0, simultaneous release
    run(0, 0, 1, 10);
    chk("forbid_qn", qn_k, 1'b1);
    run(1, 1, 1, 5);
    // Forbidden from Q=1: keep restores 1, clear forces 0
    run(0, 1, 1, 5);
    run(1, 1, 1, 3);
    run(0, 0, 1, 10);
    run(1, 1, 1, 5);
    chk("race_keep_q", q_k, 1'b1);
    chk("race_clr_q", q_c, 1'b0);
    // Forbidden released into set (no race)
    run(0, 0, 1, 5);
    run(0, 1, 1, 5);
    run(1, 1, 1, 3);
    // Reset mid-operation with S held low
    run(0, 1, 1, 5);
    step(0, 1, 0);
    chk("midreset_q", q_k, 1'b0);
    run(0, 1, 1, 5);
    run(1, 1, 1, 3);
    // Random held patterns with occasional reset
    for (int k = 0; k < 300; k++) begin
      logic rs, rr, rrst;
      rs   = 1'($urandom_range(0, 1));
      rr   = 1'($urandom_range(0, 1));
      rrst = ($urandom_range(0, 39) != 0);
      run(rs, rr, rrst, int'($urandom_range(1, 4)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_latch.md
Name: sr_latch

Overview:
- Clocked, synchronous model of an active-low set/reset (NAND-style) latch.
- S and R are asynchronous, active-low control inputs. They are synchronized, then decoded into a stored state with complementary outputs Q/Qn.
- Forbidden (both-low) and race-release conditions are flagged.
- Used as a glue/status-flag element wherever a set/clear flag driven by external strobes is needed.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops per control input; legal range 0..4, where 0 means inputs are sampled directly.
- RACE_KEEP, 1, race-release policy on S/R going low-low to high-high. 1 = restore the last valid stored state. 0 = force reset state (Q=0).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- S  input  1  active-low set request (asynchronous source).
- R  input  1  active-low reset request (asynchronous source).
- Q  output  1  latch true output, registered.
- Qn  output  1  latch complement output, registered.
- invalid  output  1  high while the synchronized S and R are both low.
- race  output  1  one-cycle pulse when both inputs leave the forbidden state on the same synchronized cycle.

Behaviour:
- Reset is synchronous and active-low: when rst_n is low at a clk rising edge, all state is reset. This includes the synchronizer flops (loaded with 1 = idle), stored state (0), Q=0, Qn=1, invalid=0 and race=0. Reset has priority over all inputs, including mid-operation.
- Synchronization: each of S and R passes through SYNC_STAGES flops, giving s_sy and r_sy. Input-to-output latency is SYNC_STAGES+1 clk rising edges.
- Decode of (s_sy, r_sy), with state and outputs registered on the same edge:
  - 1,1: hold. Q keeps the stored state; Qn = ~Q.
  - 0,1: set. Stored state becomes 1; Q=1, Qn=0.
  - 1,0: reset. Stored state becomes 0; Q=0, Qn=1.
  - 0,0: forbidden. Q=1 and Qn=1 (NAND-latch behaviour); invalid=1. The stored valid state is NOT modified.
- Leaving forbidden:
  - 0,0 to 1,1 in one synchronized cycle: race=1 for exactly one cycle. Q/Qn then take the stored state if RACE_KEEP=1, or 0/1 if RACE_KEEP=0; the stored state is updated accordingly.
  - 0,0 to 0,1 or 1,0: normal set/reset, no race pulse.
- Outside the forbidden state, Qn is always exactly ~Q. Q=Qn=1 only while invalid=1.
- invalid is registered alongside Q/Qn, so it has the same latency.
- Repeated set while set, or reset while reset: no output change, no pulse.
- Inputs are held stable for fewer than one clk period may be missed. This is by design; no pulse stretching.

Decomposition:
- Shared package sr_latch_pkg:
  - constants for the reset values (Q_RST=0, SYNC_IDLE=1);
  - an enum for the decoded input condition (HOLD, SET, RESET, FORBID).
- One sub-module, bit_synchronizer: parameterized depth, reset value, synchronous active-low reset. Instantiated twice (S, R).
- Decode, state register and race detection live in sr_latch.

Test Plan:
- Apply rst_n=0 for 2 cycles with S=R=1, then release -> Q=0, Qn=1, invalid=0, race=0 throughout.
- Drive S=0 for 10 cycles, then S=1 (SYNC_STAGES=2) -> Q=1/Qn=0 exactly 3 edges after S fell; the state holds after S returns to 1.
- Drive R=0 for 10 cycles, then R=1 -> Q=0/Qn=1 after 3 edges, then holds.
- From Q=0, drive S=R=0 for 10 cycles -> Q=1, Qn=1, invalid=1 after 3 edges. Release both together -> race=1 for one cycle, Q=0/Qn=1 (RACE_KEEP=1), invalid=0.
- Repeat the previous scenario from Q=1 with RACE_KEEP=0 -> after release, Q=0, Qn=1, race pulse of one cycle.
- Set Q=1, then assert rst_n=0 while S=0 -> at the next edge Q=0, Qn=1. After rst_n=1 with S still 0 -> Q=1 after 3 edges.
